// File: rtl/bulls_cows_round_ctrl.sv
// ---------------------------------------------------------------------------
// bulls_cows_round_ctrl
//
// Round sequencer for a two-digit Bulls-and-Cows game. One player enters a
// secret (two distinct BCD digits). The other player then gets up to
// MAX_GUESSES guesses. Each guess is scored as bulls and cows, and the score
// is held on the display for SHOW_CYCLES clocks. The round then ends in WIN
// or LOSE, and a confirm in either of those states starts a new round.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   confirm    single-cycle entry pulse (already debounced / synchronized)
//   player_in  [7:4] tens digit, [3:0] units digit, BCD
//   disp_val   4-bit code for the sevenSegment block:
//                A = enter secret, B = enter guess, {bulls,cows} = score,
//                C = win, D = lose
//   bulls      bulls of the last scored guess (0..2)
//   cows       cows of the last scored guess (0..2)
//   attempts   guesses scored this round (0..MAX_GUESSES)
//   reject     one-cycle pulse after a confirm that carried invalid digits
//   win        high in WIN
//   lose       high in LOSE
// ---------------------------------------------------------------------------
module bulls_cows_round_ctrl #(
  parameter int MAX_GUESSES = 8,
  parameter int SHOW_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       confirm,
  input  logic [7:0] player_in,
  output logic [3:0] disp_val,
  output logic [1:0] bulls,
  output logic [1:0] cows,
  output logic [3:0] attempts,
  output logic       reject,
  output logic       win,
  output logic       lose
);

  // SHOW_CYCLES-1 is the largest value the hold counter ever holds.
  localparam int HOLD_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SHOW_CYCLES - 1);
  localparam logic [3:0] MAX_ATT = 4'(MAX_GUESSES);

  typedef enum logic [2:0] {
    S_SET_SECRET,
    S_GUESS,
    S_SCORE,
    S_SHOW,
    S_WIN,
    S_LOSE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        secret_q;
  logic [7:0]        guess_q;
  logic [HOLD_W-1:0] hold_q;

  // Control strobes from the FSM to the datapath registers.
  logic ld_secret;
  logic ld_guess;
  logic do_score;
  logic clr_round;
  logic reject_d;

  // -------------------------------------------------------------------------
  // Entry validation
  // -------------------------------------------------------------------------
  logic [3:0] in_tens, in_units;
  logic       digits_bcd;
  logic       secret_ok;

  assign in_tens    = player_in[7:4];
  assign in_units   = player_in[3:0];
  assign digits_bcd = (in_tens <= 4'd9) && (in_units <= 4'd9);
  assign secret_ok  = digits_bcd && (in_tens != in_units);

  // -------------------------------------------------------------------------
  // Scoring of the captured guess against the secret
  // -------------------------------------------------------------------------
  logic [3:0] s1, s0, g1, g0;
  logic       bull1, bull0;
  logic       cow1, cow0;
  logic       no_bull;
  logic [1:0] bulls_d, cows_d;

  assign s1 = secret_q[7:4];
  assign s0 = secret_q[3:0];
  assign g1 = guess_q[7:4];
  assign g0 = guess_q[3:0];

  assign bull1   = (g1 == s1);
  assign bull0   = (g0 == s0);
  // Cows only count when neither position is a bull. The secret has distinct
  // digits, so this keeps a guess like 11 against 12 from scoring a bull and
  // a cow off the same digit.
  assign no_bull = !bull1 && !bull0;
  assign cow1    = no_bull && (g1 == s0);
  assign cow0    = no_bull && (g0 == s1);

  assign bulls_d = {1'b0, bull1} + {1'b0, bull0};
  assign cows_d  = {1'b0, cow1} + {1'b0, cow0};

  logic hold_done;
  assign hold_done = (hold_q == '0);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_SET_SECRET;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state and control strobes
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    state_d   = state_q;
    ld_secret = 1'b0;
    ld_guess  = 1'b0;
    do_score  = 1'b0;
    clr_round = 1'b0;
    reject_d  = 1'b0;

    unique case (state_q)
      S_SET_SECRET: begin
        if (confirm) begin
          if (secret_ok) begin
            ld_secret = 1'b1;
            state_d   = S_GUESS;
          end else begin
            reject_d  = 1'b1;
          end
        end
      end

      S_GUESS: begin
        if (confirm) begin
          if (digits_bcd) begin
            ld_guess = 1'b1;
            state_d  = S_SCORE;
          end else begin
            reject_d = 1'b1;
          end
        end
      end

      S_SCORE: begin
        do_score = 1'b1;
        state_d  = S_SHOW;
      end

      S_SHOW: begin
        // bulls/attempts were registered in SCORE, so they are stable here.
        if (hold_done) begin
          if (bulls == 2'd2)           state_d = S_WIN;
          else if (attempts == MAX_ATT) state_d = S_LOSE;
          else                          state_d = S_GUESS;
        end
      end

      S_WIN, S_LOSE: begin
        if (confirm) begin
          clr_round = 1'b1;
          state_d   = S_SET_SECRET;
        end
      end

      default: state_d = S_SET_SECRET;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the secret and guess are cleared by reset so a round can never
  // score against stale digits left over from before reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      secret_q <= 8'h00;
      guess_q  <= 8'h00;
      hold_q   <= '0;
      bulls    <= 2'd0;
      cows     <= 2'd0;
      attempts <= 4'd0;
      reject   <= 1'b0;
    end else begin
      reject <= reject_d;

      if (ld_secret) secret_q <= player_in;
      if (ld_guess)  guess_q  <= player_in;

      if (do_score) begin
        bulls  <= bulls_d;
        cows   <= cows_d;
        hold_q <= HOLD_LOAD;
        // Saturate: the FSM leaves the round at MAX_GUESSES anyway, this
        // only guarantees the count can never wrap.
        if (attempts < MAX_ATT) attempts <= attempts + 4'd1;
      end else if (state_q == S_SHOW && !hold_done) begin
        hold_q <= hold_q - HOLD_W'(1);
      end

      if (clr_round) begin
        bulls    <= 2'd0;
        cows     <= 2'd0;
        attempts <= 4'd0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs decoded from state
  // -------------------------------------------------------------------------
  always_comb begin
    disp_val = 4'hA;
    win      = 1'b0;
    lose     = 1'b0;
    unique case (state_q)
      S_SET_SECRET: disp_val = 4'hA;
      S_GUESS:      disp_val = 4'hB;
      S_SCORE:      disp_val = 4'hB;  // still "waiting" for the one scoring cycle
      S_SHOW:       disp_val = {bulls, cows};
      S_WIN: begin
        disp_val = 4'hC;
        win      = 1'b1;
      end
      S_LOSE: begin
        disp_val = 4'hD;
        lose     = 1'b1;
      end
      default:      disp_val = 4'hA;
    endcase
  end

endmodule

// File: doc/bulls_cows_round_ctrl.md
Name: bulls_cows_round_ctrl

Overview:
Sequences a two-digit Bulls-and-Cows round around the player comparator datapath.
- Latches a secret from one player, then accepts up to MAX_GUESSES guesses from the other.
- Scores each guess as bulls and cows, and shows each score for a fixed hold time.
- Declares win or lose.
- Drives the 4-bit value input of the existing sevenSegment display block.

Parameters:
MAX_GUESSES, 8, guesses allowed per round (1..15)
SHOW_CYCLES, 50000000, clock cycles each score is held in SHOW (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
confirm  input  1  single-cycle pulse, already debounced and synchronized
player_in  input  8  [7:4] tens digit, [3:0] units digit, BCD
disp_val  output  4  value to sevenSegment i input
bulls  output  2  bulls of last scored guess (0..2)
cows  output  2  cows of last scored guess (0..2)
attempts  output  4  guesses scored this round
reject  output  1  one-cycle pulse when confirm carried invalid digits
win  output  1  high in WIN state
lose  output  1  high in LOSE state

Behaviour:
- Reset (rst high at a clk edge) returns to SET_SECRET from any state, including mid-SHOW.
  - Reset values: bulls=0, cows=0, attempts=0, reject=0, win=0, lose=0, disp_val=4'hA.
  - Secret register is cleared, and the hold counter is cleared.
- States:
  - SET_SECRET: disp_val=4'hA. A confirm with a valid secret latches player_in as the secret and moves to GUESS next cycle.
    - Valid secret: both digits <=9 and digits distinct.
    - Invalid secret: reject pulses for 1 cycle and the state is unchanged.
  - GUESS: disp_val=4'hB. A confirm with valid digits captures the guess and moves to SCORE.
    - Valid guess: both digits <=9; repeated digits allowed.
    - Invalid guess: reject pulses, attempts is unchanged, and the state stays GUESS.
  - SCORE: exactly 1 cycle.
    - Registers bulls and cows, increments attempts, loads the hold counter with SHOW_CYCLES-1, then goes to SHOW.
  - SHOW: disp_val={bulls,cows}. The hold counter decrements each cycle. When it reaches 0, the next state is chosen in this priority:
    1. bulls==2: WIN.
    2. Otherwise attempts==MAX_GUESSES: LOSE.
    3. Otherwise: GUESS.
  - WIN: win=1, disp_val=4'hC. A confirm clears attempts, bulls and cows, and moves to SET_SECRET.
  - LOSE: lose=1, disp_val=4'hD. A confirm clears attempts, bulls and cows, and moves to SET_SECRET.
- Scoring (s1,s0 = secret digits; g1,g0 = guess digits):
  - bulls = (g1==s1) + (g0==s0).
  - cows = (g1!=s1 & g0!=s0 & g1==s0) + (g1!=s1 & g0!=s0 & g0==s1).
  - bulls+cows never exceeds 2.
- Confirm handling:
  - confirm is ignored in SCORE and SHOW: no queuing and no reject.
  - confirm asserted on the same edge as rst is ignored.
- Output timing:
  - bulls, cows and attempts are registered and hold between guesses.
  - win and lose are mutually exclusive.
  - Latency from a valid guess confirm edge to the score appearing on disp_val is 2 cycles (GUESS -> SCORE -> SHOW).
- attempts never exceeds MAX_GUESSES and never wraps.
- player_in is sampled only on a confirm cycle; changes at any other time have no effect.

Test Plan:
- Reset, then secret 8'h12 with confirm -> state GUESS and disp_val=4'hB next cycle. Guess 8'h21 -> bulls=0, cows=2, attempts=1, disp_val=4'h2 during SHOW for SHOW_CYCLES cycles (bench SHOW_CYCLES=4), then back to GUESS.
- Secret 8'h37, guess 8'h37 -> bulls=2, cows=0, disp_val=4'h8 in SHOW, then WIN with win=1 and disp_val=4'hC. A confirm then returns to SET_SECRET with attempts=0.
- Secret 8'h55 or 8'h3A -> reject pulses 1 cycle and the state stays SET_SECRET. Guess 8'hA1 in GUESS -> reject pulses and attempts is unchanged.
- MAX_GUESSES=3, secret 8'h12, guesses 8'h34, 8'h13, 8'h31:
  - Scores are (0,0), (1,0), (0,1).
  - After the third SHOW, LOSE with lose=1 and disp_val=4'hD; attempts=3.
- Confirm pulses during SCORE and SHOW -> no reject, no capture, attempts unchanged. Secret 8'h12, guess 8'h11 -> bulls=1, cows=0 (no double count).
- rst asserted mid-SHOW (hold counter at 2) -> next cycle in SET_SECRET with disp_val=4'hA and bulls, cows, attempts, win and lose all 0. A following secret and guess sequence scores correctly.
